rr_seg_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 3-bit index display (ledr + one 7-seg digit) among 8 requesters (switches).

---
 rtl/rr_seg_arbiter_pkg.sv | 43 ++++
 rtl/rr_seg_arbiter_pick.sv | 24 ++
 rtl/rr_seg_arbiter.sv | 103 ++++++++++
 tb/tb_rr_seg_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/rr_seg_arbiter_pkg.sv
// Shared types and constants for the round-robin display arbiter: state encoding,
// requester geometry and active-low seven-segment patterns {a,b,c,d,e,f,g,dp}.
package rr_seg_arbiter_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned SEG_W = 8;
  localparam int unsigned LED_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [SEG_W-1:0] SEG_0     = 8'b0000_0011;
  localparam logic [SEG_W-1:0] SEG_1     = 8'b1001_1111;
  localparam logic [SEG_W-1:0] SEG_2     = 8'b0010_0101;
  localparam logic [SEG_W-1:0] SEG_3     = 8'b0000_1101;
  localparam logic [SEG_W-1:0] SEG_4     = 8'b1001_1001;
  localparam logic [SEG_W-1:0] SEG_5     = 8'b0100_1001;
  localparam logic [SEG_W-1:0] SEG_6     = 8'b0100_0001;
  localparam logic [SEG_W-1:0] SEG_7     = 8'b0001_1111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'b1111_1111;

  // Index to digit pattern; dp stays off in every pattern.
  function automatic logic [SEG_W-1:0] seg_digit(input logic [IDX_W-1:0] d);
    logic [SEG_W-1:0] s;
    s = SEG_BLANK;
    case (d)
      3'd0: s = SEG_0;
      3'd1: s = SEG_1;
      3'd2: s = SEG_2;
      3'd3: s = SEG_3;
      3'd4: s = SEG_4;
      3'd5: s = SEG_5;
      3'd6: s = SEG_6;
      3'd7: s = SEG_7;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rr_seg_arbiter_pick.sv
// Combinational round-robin search: first asserted request starting at ptr,
// wrapping modulo N_REQ.
module rr_seg_arbiter_pick
  import rr_seg_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[ptr + IDX_W'(k)]) begin
        found = 1'b1;
        idx   = ptr + IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/rr_seg_arbiter.sv
// Round-robin arbiter sharing one index display (ledr + seg0) among eight requesters;
// each grant dwells at most HOLD_CYCLES cycles and is followed by one idle cycle.
module rr_seg_arbiter
  import rr_seg_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [LED_W-1:0] ledr,
  output logic [SEG_W-1:0] seg0
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [LED_W-1:0] ledr_q, ledr_d;
  logic [SEG_W-1:0] seg0_q, seg0_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  rr_seg_arbiter_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next state plus next value of every registered output.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ledr_d  = ledr_q;
    seg0_d  = seg0_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d  = '0;
        ledr_d = '0;
        seg0_d = SEG_BLANK;
        if (en && pick_found) begin
          state_d = ST_HOLD;
          idx_d   = pick_idx;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          gnt_d   = N_REQ'(1) << pick_idx;
          ledr_d  = {1'b1, pick_idx};
          seg0_d  = seg_digit(pick_idx);
        end
      end
      ST_HOLD: begin
        if (!en || !req[idx_q] || (cnt_q == '0)) begin
          state_d = ST_IDLE;
          ptr_d   = idx_q + IDX_W'(1);
          gnt_d   = '0;
          ledr_d  = '0;
          seg0_d  = SEG_BLANK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        ledr_d  = '0;
        seg0_d  = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ledr_q  <= '0;
      seg0_q  <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ledr_q  <= ledr_d;
      seg0_q  <= seg0_d;
    end
  end

  assign gnt  = gnt_q;
  assign ledr = ledr_q;
  assign seg0 = seg0_q;

endmodule

// File: tb/tb_rr_seg_arbiter.sv
// Directed bench for rr_seg_arbiter: default dwell of 4 plus a single-cycle-dwell instance
// sharing the same stimulus.
module tb_rr_seg_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt, gnt1;
  logic [3:0] ledr, ledr1;
  logic [7:0] seg0, seg01;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_seg_arbiter #(.HOLD_CYCLES(4), .CNT_W(3)) u_dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt), .ledr(ledr), .seg0(seg0)
  );

  rr_seg_arbiter #(.HOLD_CYCLES(1), .CNT_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt1), .ledr(ledr1), .seg0(seg01)
  );

  function automatic logic [7:0] exp_seg(input int i);
    case (i)
      0: return 8'b00000011;
      1: return 8'b10011111;
      2: return 8'b00100101;
      3: return 8'b00001101;
      4: return 8'b10011001;
      5: return 8'b01001001;
      6: return 8'b01000001;
      7: return 8'b00011111;
      default: return 8'b11111111;
    endcase
  endfunction

  function automatic logic [19:0] granted(input int i);
    logic [7:0] g;
    logic [2:0] ix;
    g  = 8'h01 << i;
    ix = 3'(i);
    return {g, 1'b1, ix, exp_seg(i)};
  endfunction

  localparam logic [19:0] IDLE = {8'h00, 4'h0, 8'hFF};

  // One rising edge, then settle at the falling edge where outputs are sampled.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed={gnt,ledr,seg0}=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held two cycles, then enabled with no requests.
    @(negedge clk);
    cyc(); cyc();
    check("reset", {gnt, ledr, seg0}, IDLE);
    check("reset_h1", {gnt1, ledr1, seg01}, IDLE);
    rst = 1'b0; en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      check($sformatf("noreq_c%0d", c), {gnt, ledr, seg0}, IDLE);
    end

    // Single requester 2: 4-cycle dwell, one idle gap, re-grant. Dwell-1 instance alternates.
    req = 8'h04;
    for (int c = 0; c < 4; c++) begin
      cyc();
      check($sformatf("r2_hold_c%0d", c), {gnt, ledr, seg0}, granted(2));
      check($sformatf("h1_c%0d", c), {gnt1, ledr1, seg01}, (c % 2 == 0) ? granted(2) : IDLE);
    end
    cyc();
    check("r2_gap", {gnt, ledr, seg0}, IDLE);
    check("h1_c4", {gnt1, ledr1, seg01}, granted(2));
    cyc();
    check("r2_regrant", {gnt, ledr, seg0}, granted(2));
    check("h1_c5", {gnt1, ledr1, seg01}, IDLE);
    req = 8'h00;
    cyc();
    check("r2_drop", {gnt, ledr, seg0}, IDLE);
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // All requesting from ptr=0: 0..7 then wrap to 0.
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 4; c++) begin
        cyc();
        check($sformatf("all_g%0d_c%0d", g, c), {gnt, ledr, seg0}, granted(g % 8));
      end
      cyc();
      check($sformatf("all_gap%0d", g), {gnt, ledr, seg0}, IDLE);
    end

    // ptr=1: grant 5, drop after 2 cycles, then req[3] found via 6,7,0..3.
    req = 8'h20;
    cyc(); check("r5_c0", {gnt, ledr, seg0}, granted(5));
    cyc(); check("r5_c1", {gnt, ledr, seg0}, granted(5));
    req = 8'h08;
    cyc(); check("r5_drop", {gnt, ledr, seg0}, IDLE);
    cyc(); check("r3_grant", {gnt, ledr, seg0}, granted(3));

    // en low mid-grant releases; re-arbitration starts at 4, not 3.
    en = 1'b0; req = 8'h18;
    cyc(); check("en_off", {gnt, ledr, seg0}, IDLE);
    en = 1'b1;
    cyc(); check("en_on_r4", {gnt, ledr, seg0}, granted(4));
    en = 1'b0; req = 8'hFF;
    cyc(); check("en_off2", {gnt, ledr, seg0}, IDLE);
    cyc(); check("en_off_idle", {gnt, ledr, seg0}, IDLE);

    // ptr=5: grant 6, then reset mid-hold; 8'hC1 must grant 0 first.
    en = 1'b1; req = 8'h40;
    cyc(); check("r6_c0", {gnt, ledr, seg0}, granted(6));
    cyc(); check("r6_c1", {gnt, ledr, seg0}, granted(6));
    rst = 1'b1; req = 8'hC1;
    cyc(); check("rst_mid", {gnt, ledr, seg0}, IDLE);
    rst = 1'b0;
    cyc(); check("post_rst_r0", {gnt, ledr, seg0}, granted(0));
    cyc(); cyc(); cyc();
    check("post_rst_r0_c3", {gnt, ledr, seg0}, granted(0));
    cyc(); check("post_rst_gap", {gnt, ledr, seg0}, IDLE);
    cyc(); check("post_rst_r6", {gnt, ledr, seg0}, granted(6));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
